// File: rtl/led_sequencer.sv
// LED colour sequencer: steps a colour code through [MIN_VAL..MAX_VAL] from a
// synchronised push-button, with up/down/single-step/ping-pong modes and a rate prescaler.
module led_sequencer #(
    parameter int unsigned WIDTH   = 3,
    parameter int unsigned MIN_VAL = 1,
    parameter int unsigned MAX_VAL = 6,
    parameter int unsigned RATE_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              button,
    input  logic [1:0]        mode,
    input  logic [RATE_W-1:0] rate,
    output logic [WIDTH-1:0]  colour,
    output logic              wrap
);

    localparam logic [WIDTH-1:0]  MIN_C   = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0]  MAX_C   = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0]  MIN_P1  = WIDTH'(MIN_VAL + 1);
    localparam logic [WIDTH-1:0]  MAX_M1  = WIDTH'(MAX_VAL - 1);
    localparam logic [WIDTH-1:0]  ONE_C   = WIDTH'(1);
    localparam logic [RATE_W-1:0] CNT_ONE = RATE_W'(1);

    localparam logic [1:0] MODE_UP     = 2'b00;
    localparam logic [1:0] MODE_DOWN   = 2'b01;
    localparam logic [1:0] MODE_SINGLE = 2'b10;
    localparam logic [1:0] MODE_PING   = 2'b11;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    logic              sync1;
    logic              btn_s;
    logic              btn_prev;
    logic [1:0]        mode_q;
    logic [RATE_W-1:0] cnt_q;
    logic [RATE_W-1:0] cnt_d;
    logic [WIDTH-1:0]  colour_q;
    logic [WIDTH-1:0]  colour_d;
    logic              wrap_q;
    logic              wrap_d;
    dir_t              dir_q;
    dir_t              dir_d;
    logic              illegal_c;
    logic              mode_chg_c;
    logic              step_c;

    assign illegal_c  = (colour_q < MIN_C) || (colour_q > MAX_C);
    assign mode_chg_c = (mode != mode_q);

    // Two-flop button synchroniser plus edge-detect history and mode history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1    <= 1'b0;
            btn_s    <= 1'b0;
            btn_prev <= 1'b0;
            mode_q   <= MODE_UP;
        end else begin
            sync1    <= button;
            btn_s    <= sync1;
            btn_prev <= btn_s;
            mode_q   <= mode;
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            colour_q <= MIN_C;
            cnt_q    <= '0;
            wrap_q   <= 1'b0;
            dir_q    <= DIR_UP;
        end else begin
            colour_q <= colour_d;
            cnt_q    <= cnt_d;
            wrap_q   <= wrap_d;
            dir_q    <= dir_d;
        end
    end

    // Next-state: recovery, then mode change, then prescaler/edge qualified stepping.
    always_comb begin
        colour_d = colour_q;
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        wrap_d   = 1'b0;
        step_c   = 1'b0;

        if (mode_chg_c && (mode_q == MODE_PING)) begin
            dir_d = DIR_UP;
        end

        if (illegal_c) begin
            colour_d = MIN_C;
            cnt_d    = '0;
        end else if (mode_chg_c) begin
            cnt_d = '0;
        end else if (mode == MODE_SINGLE) begin
            cnt_d  = '0;
            step_c = btn_s & ~btn_prev;
        end else if (!btn_s) begin
            cnt_d = '0;
        end else if (cnt_q == rate) begin
            cnt_d  = '0;
            step_c = 1'b1;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end

        // Endpoints are tested before +1/-1 so arithmetic never leaves the range.
        if (step_c) begin
            case (mode)
                MODE_DOWN: begin
                    if (colour_q == MIN_C) begin
                        colour_d = MAX_C;
                        wrap_d   = 1'b1;
                    end else begin
                        colour_d = colour_q - ONE_C;
                    end
                end
                MODE_PING: begin
                    if (dir_q == DIR_UP) begin
                        if (colour_q == MAX_C) begin
                            colour_d = colour_q - ONE_C;
                            dir_d    = DIR_DOWN;
                            wrap_d   = 1'b1;
                        end else begin
                            colour_d = colour_q + ONE_C;
                            if (colour_q == MAX_M1) begin
                                dir_d  = DIR_DOWN;
                                wrap_d = 1'b1;
                            end
                        end
                    end else begin
                        if (colour_q == MIN_C) begin
                            colour_d = colour_q + ONE_C;
                            dir_d    = DIR_UP;
                            wrap_d   = 1'b1;
                        end else begin
                            colour_d = colour_q - ONE_C;
                            if (colour_q == MIN_P1) begin
                                dir_d  = DIR_UP;
                                wrap_d = 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    if (colour_q == MAX_C) begin
                        colour_d = MIN_C;
                        wrap_d   = 1'b1;
                    end else begin
                        colour_d = colour_q + ONE_C;
                    end
                end
            endcase
        end
    end

    assign colour = colour_q;
    assign wrap   = wrap_q;

endmodule
